// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and mode decode for the PWM output stage.
package pwm_pkg;

  localparam int CNT_W_DEFAULT  = 16;
  localparam int FUNC_W_DEFAULT = 8;

  localparam int FUNC_ALIGN_BIT   = 0;
  localparam int FUNC_UNALIGN_BIT = 1;

  localparam logic [1:0] MODE_LEFT      = 2'b00;
  localparam logic [1:0] MODE_RIGHT     = 2'b01;
  localparam logic [1:0] MODE_UNALIGNED = 2'b10;

  // The unaligned bit overrides the align bit, so 2'b11 also selects the window mode.
  function automatic logic [1:0] decode_mode(input logic unalign, input logic align);
    logic [1:0] mode;
    if (unalign) begin
      mode = MODE_UNALIGNED;
    end else if (align) begin
      mode = MODE_RIGHT;
    end else begin
      mode = MODE_LEFT;
    end
    return mode;
  endfunction

endpackage

// File: rtl/pwm_shadow_regs.sv
// pwm_shadow_regs: holds functions/compare1/compare2 so that a new configuration
// only takes effect at the period boundary (count_val == period) or while PWM is off.
module pwm_shadow_regs
  import pwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int FUNC_W = FUNC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_en,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  count_val,
  input  logic [FUNC_W-1:0] functions_in,
  input  logic [CNT_W-1:0]  compare1_in,
  input  logic [CNT_W-1:0]  compare2_in,
  output logic [FUNC_W-1:0] functions_sh,
  output logic [CNT_W-1:0]  compare1_sh,
  output logic [CNT_W-1:0]  compare2_sh
);

  logic              load;
  logic [FUNC_W-1:0] functions_d, functions_q;
  logic [CNT_W-1:0]  compare1_d, compare1_q;
  logic [CNT_W-1:0]  compare2_d, compare2_q;

  // Select new configuration at the last count of the period or whenever PWM is disabled.
  always_comb begin
    load        = (!pwm_en) || (count_val == period);
    functions_d = functions_q;
    compare1_d  = compare1_q;
    compare2_d  = compare2_q;
    if (load) begin
      functions_d = functions_in;
      compare1_d  = compare1_in;
      compare2_d  = compare2_in;
    end
  end

  // Shadow registers, cleared to left mode with zero thresholds on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      functions_q <= '0;
      compare1_q  <= '0;
      compare2_q  <= '0;
    end else begin
      functions_q <= functions_d;
      compare1_q  <= compare1_d;
      compare2_q  <= compare2_d;
    end
  end

  assign functions_sh = functions_q;
  assign compare1_sh  = compare1_q;
  assign compare2_sh  = compare2_q;

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: combinational PWM output stage comparing an external counter against
// thresholds in left-, right-aligned or unaligned (window) mode.
// Optional build macro PWM_SHADOW_EN: registers functions/compare1/compare2 and
// updates them only at the period boundary or while pwm_en is low.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int FUNC_W = FUNC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_en,
  input  logic [CNT_W-1:0]  period,
  input  logic [FUNC_W-1:0] functions,
  input  logic [CNT_W-1:0]  compare1,
  input  logic [CNT_W-1:0]  compare2,
  input  logic [CNT_W-1:0]  count_val,
  output logic              pwm_out
);

  logic [FUNC_W-1:0] functions_eff;
  logic [CNT_W-1:0]  compare1_eff;
  logic [CNT_W-1:0]  compare2_eff;

`ifdef PWM_SHADOW_EN
  pwm_shadow_regs #(
    .CNT_W  (CNT_W),
    .FUNC_W (FUNC_W)
  ) u_shadow (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_en       (pwm_en),
    .period       (period),
    .count_val    (count_val),
    .functions_in (functions),
    .compare1_in  (compare1),
    .compare2_in  (compare2),
    .functions_sh (functions_eff),
    .compare1_sh  (compare1_eff),
    .compare2_sh  (compare2_eff)
  );
`else
  // Without shadowing the configuration is used as-is and no clock is needed.
  logic unused_clk;
  assign unused_clk    = clk;
  assign functions_eff = functions;
  assign compare1_eff  = compare1;
  assign compare2_eff  = compare2;
`endif

  // Reserved function bits have no effect.
  logic unused_func_bits;
  assign unused_func_bits = ^functions_eff[FUNC_W-1:2];

  logic [1:0] mode;
  logic       in_range;
  logic       below_c1;
  logic       below_c2;
  logic       level;

  // Unsigned compares and mode mux; output forced low by reset, disable or out-of-range count.
  always_comb begin
    mode     = decode_mode(functions_eff[FUNC_UNALIGN_BIT], functions_eff[FUNC_ALIGN_BIT]);
    in_range = (count_val <= period);
    below_c1 = (count_val < compare1_eff);
    below_c2 = (count_val < compare2_eff);
    level    = 1'b0;
    case (mode)
      MODE_LEFT:  level = below_c1;
      MODE_RIGHT: level = !below_c1;
      default:    level = (!below_c1) && below_c2;
    endcase
    pwm_out = rst_n && pwm_en && in_range && level;
  end

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed vectors with a scoreboard queue; a negedge monitor pops and compares.
module tb_pwm_gen;

  logic        clk;
  logic        rst_n;
  logic        pwm_en;
  logic [15:0] period;
  logic [7:0]  functions;
  logic [15:0] compare1;
  logic [15:0] compare2;
  logic [15:0] count_val;
  logic        pwm_out;

  pwm_gen #(.CNT_W(16), .FUNC_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_en    (pwm_en),
    .period    (period),
    .functions (functions),
    .compare1  (compare1),
    .compare2  (compare2),
    .count_val (count_val),
    .pwm_out   (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic  exp_q[$];
  string name_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  // Monitor: output is valid by mid-cycle; compare against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if (pwm_out !== e) begin
        n_miss++;
        $display("FAIL %s: pwm_out=%b expected=%b (cnt=%0d c1=%0d c2=%0d f=%h en=%b rst_n=%b)",
                 nm, pwm_out, e, count_val, compare1, compare2, functions, pwm_en, rst_n);
      end
    end
  end

  task automatic drive(input logic rst, input logic en, input logic [7:0] f,
                       input logic [15:0] per, input logic [15:0] c1, input logic [15:0] c2,
                       input logic [15:0] cnt);
    rst_n     = rst;
    pwm_en    = en;
    functions = f;
    period    = per;
    compare1  = c1;
    compare2  = c2;
    count_val = cnt;
  endtask

  // One raw cycle: drive just after the rising edge and queue the expected level.
  task automatic step(input string nm, input logic rst, input logic en, input logic [7:0] f,
                      input logic [15:0] per, input logic [15:0] c1, input logic [15:0] c2,
                      input logic [15:0] cnt, input logic exp);
    @(posedge clk);
    #1;
    drive(rst, en, f, per, c1, c2, cnt);
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // A vector that assumes the configuration is live; with shadowing, load it first.
  task automatic apply(input string nm, input logic rst, input logic en, input logic [7:0] f,
                       input logic [15:0] per, input logic [15:0] c1, input logic [15:0] c2,
                       input logic [15:0] cnt, input logic exp);
`ifdef PWM_SHADOW_EN
    @(posedge clk);
    #1;
    drive(rst, 1'b0, f, per, c1, c2, cnt);
`endif
    step(nm, rst, en, f, per, c1, c2, cnt, exp);
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h00, 16'd8, 16'd3, 16'd6, 16'd0);

    apply("reset_state",    1'b0, 1'b1, 8'h00, 16'd8, 16'd3, 16'd6, 16'd0, 1'b0);

    apply("dis_cnt0",       1'b1, 1'b0, 8'h00, 16'd8, 16'd3, 16'd6, 16'd0, 1'b0);
    apply("dis_cnt3",       1'b1, 1'b0, 8'h00, 16'd8, 16'd3, 16'd6, 16'd3, 1'b0);

    apply("left_cnt0",      1'b1, 1'b1, 8'h00, 16'd8, 16'd3, 16'd6, 16'd0, 1'b1);
    apply("left_cnt2",      1'b1, 1'b1, 8'h00, 16'd8, 16'd3, 16'd6, 16'd2, 1'b1);
    apply("left_cnt3",      1'b1, 1'b1, 8'h00, 16'd8, 16'd3, 16'd6, 16'd3, 1'b0);
    apply("left_cnt8",      1'b1, 1'b1, 8'h00, 16'd8, 16'd3, 16'd6, 16'd8, 1'b0);
    apply("left_wrap0",     1'b1, 1'b1, 8'h00, 16'd8, 16'd3, 16'd6, 16'd0, 1'b1);

    apply("right_cnt0",     1'b1, 1'b1, 8'h01, 16'd8, 16'd3, 16'd6, 16'd0, 1'b0);
    apply("right_cnt2",     1'b1, 1'b1, 8'h01, 16'd8, 16'd3, 16'd6, 16'd2, 1'b0);
    apply("right_cnt3",     1'b1, 1'b1, 8'h01, 16'd8, 16'd3, 16'd6, 16'd3, 1'b1);
    apply("right_cnt8",     1'b1, 1'b1, 8'h01, 16'd8, 16'd3, 16'd6, 16'd8, 1'b1);
    apply("right_wrap0",    1'b1, 1'b1, 8'h01, 16'd8, 16'd3, 16'd6, 16'd0, 1'b0);

    for (int rep = 0; rep < 2; rep++) begin
      apply("unal_cnt0",    1'b1, 1'b1, 8'h02, 16'd8, 16'd3, 16'd6, 16'd0, 1'b0);
      apply("unal_cnt3",    1'b1, 1'b1, 8'h02, 16'd8, 16'd3, 16'd6, 16'd3, 1'b1);
      apply("unal_cnt5",    1'b1, 1'b1, 8'h02, 16'd8, 16'd3, 16'd6, 16'd5, 1'b1);
      apply("unal_cnt6",    1'b1, 1'b1, 8'h02, 16'd8, 16'd3, 16'd6, 16'd6, 1'b0);
      apply("unal_cnt8",    1'b1, 1'b1, 8'h02, 16'd8, 16'd3, 16'd6, 16'd8, 1'b0);
    end
    apply("unal11_cnt3",    1'b1, 1'b1, 8'h03, 16'd8, 16'd3, 16'd6, 16'd3, 1'b1);
    apply("unal11_cnt2",    1'b1, 1'b1, 8'h03, 16'd8, 16'd3, 16'd6, 16'd2, 1'b0);

    apply("resv_left",      1'b1, 1'b1, 8'hFC, 16'd8, 16'd3, 16'd6, 16'd0, 1'b1);
    apply("resv_right",     1'b1, 1'b1, 8'hFD, 16'd8, 16'd3, 16'd6, 16'd0, 1'b0);

    apply("left_c1_0_cnt0", 1'b1, 1'b1, 8'h00, 16'd8, 16'd0, 16'd6, 16'd0, 1'b0);
    apply("left_c1_0_cnt5", 1'b1, 1'b1, 8'h00, 16'd8, 16'd0, 16'd6, 16'd5, 1'b0);
    apply("left_c1big_8",   1'b1, 1'b1, 8'h00, 16'd8, 16'd10, 16'd6, 16'd8, 1'b1);
    apply("right_c1_0",     1'b1, 1'b1, 8'h01, 16'd8, 16'd0, 16'd6, 16'd0, 1'b1);
    apply("unal_inv_cnt3",  1'b1, 1'b1, 8'h02, 16'd8, 16'd6, 16'd3, 16'd3, 1'b0);
    apply("unal_inv_cnt4",  1'b1, 1'b1, 8'h02, 16'd8, 16'd6, 16'd3, 16'd4, 1'b0);
    apply("unal_inv_cnt6",  1'b1, 1'b1, 8'h02, 16'd8, 16'd6, 16'd3, 16'd6, 1'b0);
    apply("oor_right_9",    1'b1, 1'b1, 8'h01, 16'd8, 16'd3, 16'd6, 16'd9, 1'b0);
    apply("oor_left_9",     1'b1, 1'b1, 8'h00, 16'd8, 16'd10, 16'd6, 16'd9, 1'b0);

    apply("wide_below",     1'b1, 1'b1, 8'h00, 16'hFFFF, 16'h8000, 16'd6, 16'h7FFF, 1'b1);
    apply("wide_at",        1'b1, 1'b1, 8'h00, 16'hFFFF, 16'h8000, 16'd6, 16'h8000, 1'b0);
    apply("wide_top",       1'b1, 1'b1, 8'h01, 16'hFFFF, 16'h8000, 16'd6, 16'hFFFF, 1'b1);

    apply("pre_rst_right5", 1'b1, 1'b1, 8'h01, 16'd8, 16'd3, 16'd6, 16'd5, 1'b1);
    step ("rst_mid_period", 1'b0, 1'b1, 8'h01, 16'd8, 16'd3, 16'd6, 16'd5, 1'b0);
    apply("post_rst_right5",1'b1, 1'b1, 8'h01, 16'd8, 16'd3, 16'd6, 16'd5, 1'b1);

`ifdef PWM_SHADOW_EN
    apply("sh_left_cnt1",   1'b1, 1'b1, 8'h00, 16'd8, 16'd3, 16'd6, 16'd1, 1'b1);
    step ("sh_chg_cnt2",    1'b1, 1'b1, 8'h00, 16'd8, 16'd5, 16'd6, 16'd2, 1'b1);
    step ("sh_old_cnt4",    1'b1, 1'b1, 8'h00, 16'd8, 16'd5, 16'd6, 16'd4, 1'b0);
    step ("sh_cnt8",        1'b1, 1'b1, 8'h00, 16'd8, 16'd5, 16'd6, 16'd8, 1'b0);
    step ("sh_wrap0",       1'b1, 1'b1, 8'h00, 16'd8, 16'd5, 16'd6, 16'd0, 1'b1);
    step ("sh_new_cnt4",    1'b1, 1'b1, 8'h00, 16'd8, 16'd5, 16'd6, 16'd4, 1'b1);
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
